fpadd_accum_seq: RTL

Operand sequencer that sits directly upstream of the `fpadd` single-precision adder. It accepts a stream of IEEE-754 single-precision words over a valid/ready handshake and issues one `start` pulse per operand pair. It waits for the adder's `done`, feeds the returned sum back as the running accumulator, and emits the final accumulated value when the operand tagged `in_last` has been added. It also reports the operand count and a timeout error.

---
 rtl/fpadd_accum_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fpadd_accum_seq.sv
// ============================================================================
// Module      : fpadd_accum_seq
// Description : Operand sequencer feeding an external fpadd unit; accumulates
//               a stream of single-precision words and emits the final sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpadd_accum_seq #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             add_start,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  input  logic             add_done,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err,
  input  logic             out_ready
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_acc   = 3'd1;
  localparam logic [2:0] c_st_start = 3'd2;
  localparam logic [2:0] c_st_wait  = 3'd3;
  localparam logic [2:0] c_st_out   = 3'd4;

  localparam logic [7:0]       c_timer_last = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_cnt_max    = '1;
  localparam logic [CNT_W-1:0] c_cnt_one    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [31:0]      r_acc;
  logic [31:0]      r_add_a;
  logic [31:0]      r_add_b;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_timer;
  logic             r_err;
  logic             r_last;
  logic             w_done_ok;
  logic             w_timeout;

  // The adder clears done on the start edge, so a done seen at timer 0 is stale.
  assign w_done_ok = (r_timer != 8'd0) && add_done;
  assign w_timeout = (r_timer == c_timer_last) && !w_done_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (in_valid) begin
          w_next = in_last ? c_st_out : c_st_acc;
        end
      end
      c_st_acc: begin
        if (in_valid) begin
          w_next = c_st_start;
        end
      end
      c_st_start: begin
        w_next = c_st_wait;
      end
      c_st_wait: begin
        if (w_done_ok) begin
          w_next = r_last ? c_st_out : c_st_acc;
        end else if (w_timeout) begin
          w_next = c_st_out;
        end
      end
      c_st_out: begin
        if (out_ready) begin
          w_next = c_st_idle;
        end
      end
      default: begin
        w_next = c_st_idle;
      end
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_st_idle) || (r_state == c_st_acc);
    add_start = (r_state == c_st_start);
    out_valid = (r_state == c_st_out);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc   <= 32'd0;
      r_add_a <= 32'd0;
      r_add_b <= 32'd0;
      r_cnt   <= '0;
      r_timer <= 8'd0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_acc <= in_data;
            r_cnt <= c_cnt_one;
          end
        end
        c_st_acc: begin
          if (in_valid) begin
            r_add_a <= r_acc;
            r_add_b <= in_data;
            r_last  <= in_last;
            if (r_cnt != c_cnt_max) begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end
        end
        c_st_start: begin
          r_timer <= 8'd0;
        end
        c_st_wait: begin
          r_timer <= r_timer + 8'd1;
          if (w_done_ok) begin
            r_acc <= add_sum;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        c_st_out: begin
          if (out_ready) begin
            r_err <= 1'b0;
          end
        end
        default: begin
          r_timer <= 8'd0;
        end
      endcase
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign out_data  = r_acc;
  assign out_count = r_cnt;
  assign out_err   = r_err;

endmodule

`default_nettype wire
